// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared decode enums, sequencer state encoding and the
// branch-resolution helper used by control_sequencer.
`default_nettype none

package control_sequencer_pkg;

    localparam int unsigned RETIRE_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_OP_ADD     = 4'd0,
        ALU_OP_SUB     = 4'd1,
        ALU_OP_AND     = 4'd2,
        ALU_OP_OR      = 4'd3,
        ALU_OP_XOR     = 4'd4,
        ALU_OP_SLT     = 4'd5,
        ALU_OP_SLL     = 4'd6,
        ALU_OP_SRL     = 4'd7,
        ALU_OP_INVALID = 4'hF
    } t_alu_operation;

    typedef enum logic [1:0] {
        BRANCH_NONE = 2'd0,
        BRANCH_NE   = 2'd1,
        BRANCH_JUMP = 2'd2
    } t_branch_condition;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5,
        ST_TRAP      = 3'd6
    } t_sequencer_state;

    function automatic logic branch_taken(input t_branch_condition cond,
                                          input logic              alu_zero);
        return (cond == BRANCH_JUMP) || ((cond == BRANCH_NE) && !alu_zero);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_instret.sv
// instret_counter: free-running retired-instruction counter, wraps modulo 2^32.
`default_nettype none

module instret_counter
    import control_sequencer_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_increment,
    output logic [RETIRE_WIDTH-1:0] o_count
);

    logic [RETIRE_WIDTH-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else if (i_increment) begin
            count_q <= count_q + RETIRE_WIDTH'(1);
        end
    end

    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM
// with fetch timeout. Optional illegal-instruction trap state under SEQUENCER_TRAP_EN.
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_imem_valid,
    input  logic              i_dmem_ready,
    input  t_alu_operation    i_alu_operation,
    input  t_branch_condition i_branch_condition,
    input  logic              i_destination_register_write_enable,
    input  logic              i_memory_write_enable,
    input  logic              i_alu_zero,
    input  logic              i_halt,
    output logic              o_imem_request,
    output logic              o_instruction_load,
    output logic              o_dmem_request,
    output logic              o_register_write_enable,
    output logic              o_pc_write_enable,
    output logic              o_pc_select,
    output t_sequencer_state  o_state,
    output logic [31:0]       o_retired_count,
    output logic              o_fetch_fault
`ifdef SEQUENCER_TRAP_EN
    ,
    output logic              o_illegal_instruction
`endif
);

    localparam int unsigned WAIT_W = $clog2(FETCH_TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT_CYCLES - 1);

    t_sequencer_state  state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;

    logic imem_req, instr_load, dmem_req, reg_we, pc_we, pc_sel, retire, illegal;
    logic invalid_as_nop;

`ifdef SEQUENCER_TRAP_EN
    assign invalid_as_nop = 1'b0;
`else
    assign invalid_as_nop = (i_alu_operation == ALU_OP_INVALID);
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // wait_d defaults to zero so the counter is clear whenever FETCH is entered.
    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        fault_d    = fault_q;
        imem_req   = 1'b0;
        instr_load = 1'b0;
        dmem_req   = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                wait_d   = wait_q + WAIT_W'(1);
                if (i_imem_valid) begin
                    instr_load = 1'b1;
                    state_d    = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
`ifdef SEQUENCER_TRAP_EN
                if ((i_alu_operation == ALU_OP_INVALID) &&
                    (i_branch_condition != BRANCH_JUMP)) begin
                    state_d = ST_TRAP;
                end else
`endif
                if (i_memory_write_enable) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                if (i_dmem_ready) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                pc_we   = 1'b1;
                retire  = 1'b1;
                reg_we  = i_destination_register_write_enable && !invalid_as_nop;
                pc_sel  = !invalid_as_nop && branch_taken(i_branch_condition, i_alu_zero);
                state_d = i_halt ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: state_d = ST_HALTED;
`ifdef SEQUENCER_TRAP_EN
            ST_TRAP: illegal = 1'b1;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    instret_counter u_instret (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_increment (retire),
        .o_count     (o_retired_count)
    );

    // Strobes are gated by the reset pin so they drop immediately, not at the next edge.
    assign o_imem_request          = imem_req   & i_reset_n;
    assign o_instruction_load      = instr_load & i_reset_n;
    assign o_dmem_request          = dmem_req   & i_reset_n;
    assign o_register_write_enable = reg_we     & i_reset_n;
    assign o_pc_write_enable       = pc_we      & i_reset_n;
    assign o_pc_select             = pc_sel     & i_reset_n;
    assign o_state                 = state_q;
    assign o_fetch_fault           = fault_q;

`ifdef SEQUENCER_TRAP_EN
    assign o_illegal_instruction = illegal & i_reset_n;
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction stream with a scoreboard of
// per-instruction retirement expectations, plus directed timeout/halt/reset cases.
`default_nettype none

module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              i_reset_n = 1'b1;
    logic              i_imem_valid = 1'b0;
    logic              i_dmem_ready = 1'b0;
    t_alu_operation    i_alu_operation = ALU_OP_ADD;
    t_branch_condition i_branch_condition = BRANCH_NONE;
    logic              i_dest_we = 1'b0;
    logic              i_mem_we = 1'b0;
    logic              i_alu_zero = 1'b0;
    logic              i_halt = 1'b0;
    logic              o_imem_request, o_instruction_load, o_dmem_request;
    logic              o_register_write_enable, o_pc_write_enable, o_pc_select;
    t_sequencer_state  o_state;
    logic [31:0]       o_retired_count;
    logic              o_fetch_fault;
`ifdef SEQUENCER_TRAP_EN
    logic              o_illegal_instruction;
`endif

    control_sequencer #(.FETCH_TIMEOUT_CYCLES(16)) dut (
        .i_clk                               (clk),
        .i_reset_n                           (i_reset_n),
        .i_imem_valid                        (i_imem_valid),
        .i_dmem_ready                        (i_dmem_ready),
        .i_alu_operation                     (i_alu_operation),
        .i_branch_condition                  (i_branch_condition),
        .i_destination_register_write_enable (i_dest_we),
        .i_memory_write_enable               (i_mem_we),
        .i_alu_zero                          (i_alu_zero),
        .i_halt                              (i_halt),
        .o_imem_request                      (o_imem_request),
        .o_instruction_load                  (o_instruction_load),
        .o_dmem_request                      (o_dmem_request),
        .o_register_write_enable             (o_register_write_enable),
        .o_pc_write_enable                   (o_pc_write_enable),
        .o_pc_select                         (o_pc_select),
        .o_state                             (o_state),
        .o_retired_count                     (o_retired_count),
        .o_fetch_fault                       (o_fetch_fault)
`ifdef SEQUENCER_TRAP_EN
        ,
        .o_illegal_instruction               (o_illegal_instruction)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reg_we;
        logic        pc_sel;
        int          dmem_cycles;
        int          latency;
        logic [31:0] count_before;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {o_imem_request, o_instruction_load, o_dmem_request,
                o_register_write_enable, o_pc_write_enable, o_pc_select};
    endfunction

    // Monitor: pops one expectation per write-back strobe.
    int cyc = 0, load_cyc = 0, mem_n = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!i_reset_n) begin
                mem_n = 0;
            end else begin
                if (o_instruction_load) begin
                    load_cyc = cyc;
                    mem_n    = 0;
                end
                if (o_dmem_request) mem_n++;
                if (o_pc_write_enable) begin
                    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("reg_we", 32'(o_register_write_enable), 32'(e.reg_we));
                        chk("pc_select", 32'(o_pc_select), 32'(e.pc_sel));
                        chk("dmem_cycles", mem_n, e.dmem_cycles);
                        chk("latency", cyc - load_cyc, e.latency);
                        chk("count_at_wb", o_retired_count, e.count_before);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        i_reset_n    = 1'b0;
        i_imem_valid = 1'b0;
        i_dmem_ready = 1'b0;
        i_halt       = 1'b0;
        sb.delete();
        model_count  = 0;
        #1;
        chk("rst_state", 32'(o_state), 32'(ST_FETCH));
        chk("rst_count", o_retired_count, 32'd0);
        chk("rst_fault", 32'(o_fetch_fault), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'd0);
        step();
        step();
        i_reset_n = 1'b1;
    endtask

    // Drives one instruction from FETCH through write-back; fd = idle FETCH cycles,
    // md = MEMORY cycles with i_dmem_ready low before acceptance.
    task automatic run_instr(input t_alu_operation op, input t_branch_condition br,
                             input logic we, input logic mw, input logic zero,
                             input logic halt, input int fd, input int md);
        exp_t e;
        int   guard = 0;
        int   mcnt = 0;
        logic invalid;
        invalid = (op == ALU_OP_INVALID);
        e.reg_we       = we && !invalid;
        e.pc_sel       = !invalid && ((br == BRANCH_JUMP) || (br == BRANCH_NE && !zero));
        e.dmem_cycles  = mw ? md + 1 : 0;
        e.latency      = 3 + e.dmem_cycles;
        e.count_before = model_count;
        model_count    = model_count + 1;
        sb.push_back(e);
        i_alu_operation    = op;
        i_branch_condition = br;
        i_dest_we          = we;
        i_mem_we           = mw;
        i_alu_zero         = zero;
        i_halt             = halt;
        i_imem_valid       = 1'b0;
        repeat (fd) step();
        i_imem_valid = 1'b1;
        step();
        i_imem_valid = 1'b0;
        chk("decode_after_load", 32'(o_state), 32'(ST_DECODE));
        while (!o_pc_write_enable && guard < 60) begin
            i_dmem_ready = o_dmem_request && (mcnt == md);
            if (o_dmem_request) mcnt++;
            step();
            guard++;
        end
        i_dmem_ready = 1'b0;
        chk("wb_reached", 32'(guard < 60), 32'd1);
        step();
        i_halt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        t_alu_operation op;
        #2;
        do_reset();

        // Directed: ADD, 3-cycle stalled store, NE both ways, final-cycle fetch, NOP op.
        run_instr(ALU_OP_ADD, BRANCH_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("add_count", o_retired_count, 32'd1);
        run_instr(ALU_OP_ADD, BRANCH_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
        run_instr(ALU_OP_SUB, BRANCH_NE, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        run_instr(ALU_OP_SUB, BRANCH_NE, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0);
        run_instr(ALU_OP_OR, BRANCH_JUMP, 1'b1, 1'b0, 1'b1, 1'b0, 15, 0);
`ifndef SEQUENCER_TRAP_EN
        run_instr(ALU_OP_INVALID, BRANCH_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
`ifdef SEQUENCER_TRAP_EN
            if (r >= 8) r = 0;
`endif
            op = (r >= 8) ? ALU_OP_INVALID : t_alu_operation'(r[3:0]);
            run_instr(op, t_branch_condition'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0,
                      $urandom_range(0, 4), $urandom_range(0, 3));
        end
        chk("retired_total", o_retired_count, model_count);
        chk("sb_drained", sb.size(), 32'd0);

        // Reset while a store is stalled in MEMORY.
        i_alu_operation = ALU_OP_ADD;
        i_branch_condition = BRANCH_NONE;
        i_dest_we = 1'b1;
        i_mem_we = 1'b1;
        i_imem_valid = 1'b1;
        step();
        i_imem_valid = 1'b0;
        step();
        step();
        chk("mid_mem_state", 32'(o_state), 32'(ST_MEMORY));
        chk("mid_mem_req", 32'(o_dmem_request), 32'd1);
        step();
        do_reset();

        // Fetch timeout with i_imem_valid held low.
        begin
            int n = 0;
            while (!o_fetch_fault && n < 40) begin
                step();
                n++;
            end
            chk("timeout_cycles", n, 32'd16);
            chk("timeout_state", 32'(o_state), 32'(ST_HALTED));
            chk("timeout_imem_req", 32'(o_imem_request), 32'd0);
        end
        do_reset();
        chk("fault_cleared", 32'(o_fetch_fault), 32'd0);

        // Halt after write-back; HALTED is terminal.
        run_instr(ALU_OP_XOR, BRANCH_NONE, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("halt_state", 32'(o_state), 32'(ST_HALTED));
        i_imem_valid = 1'b1;
        repeat (5) step();
        chk("halted_stays", 32'(o_state), 32'(ST_HALTED));
        chk("halted_strobes", 32'(strobes()), 32'd0);
        chk("halted_count", o_retired_count, 32'd1);
        i_imem_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
